// File: rtl/i2c_seq_config_pkg.sv
// Shared opcodes, sequencer states and table entry layout for i2c_seq_config.
package i2c_seq_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_END,
    S_DELAY,
    S_FINISH
  } seq_state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] regaddr;
    logic [7:0] data;
  } seq_entry_t;

endpackage

// File: rtl/i2c_seq_config_i2c.sv
// Write-only I2C master: sends one 3-byte frame per START, ACK = OR of the three ack bits.
// No reset: the all-zero register state is the idle bus, so a frame always runs to its STOP.
module i2c #(
  parameter int CLK_HZ = 50_000_000,
  parameter int I2C_HZ = 20_000
) (
  input  logic        iCLK,
  input  logic        START,
  input  logic [23:0] I2C_DATA,
  output logic        END,
  output logic        ACK,
  output logic        I2C_SCL,
  inout  wire         I2C_SDA
);

  localparam int QDIV = (CLK_HZ / (4 * I2C_HZ)) < 1 ? 1 : (CLK_HZ / (4 * I2C_HZ));
  localparam int DW   = $clog2(QDIV + 1);

  logic          r_busy;
  logic          r_scl_low;
  logic          r_sda_low;
  logic          r_ack;
  logic [DW-1:0] r_div;
  logic [1:0]    r_phase;
  logic [4:0]    r_slot;
  logic [3:0]    r_bit;
  logic [23:0]   r_shift;
  logic          w_tick;
  logic          w_ack_slot;

  assign w_tick     = (r_div == '0);
  assign w_ack_slot = (r_bit == 4'd8);

  // Slot 0 is the START condition, slots 1..27 are 3 x (8 data + ack), slot 28 is STOP.
  always_ff @(posedge iCLK) begin
    if (!r_busy) begin
      if (START) begin
        r_busy  <= 1'b1;
        r_ack   <= 1'b0;
        r_shift <= I2C_DATA;
        r_slot  <= 5'd0;
        r_bit   <= 4'd0;
        r_phase <= 2'd0;
        r_div   <= DW'(QDIV - 1);
      end
    end else begin
      r_div <= w_tick ? DW'(QDIV - 1) : r_div - 1'b1;
      if (w_tick) begin
        r_phase <= r_phase + 2'd1;
        if (r_slot == 5'd0) begin
          if (r_phase == 2'd0) r_sda_low <= 1'b1;
        end else if (r_slot == 5'd28) begin
          case (r_phase)
            2'd0: r_scl_low <= 1'b1;
            2'd1: r_sda_low <= 1'b1;
            2'd2: r_scl_low <= 1'b0;
            2'd3: begin
              r_sda_low <= 1'b0;
              r_busy    <= 1'b0;
            end
          endcase
        end else begin
          case (r_phase)
            2'd0: r_scl_low <= 1'b1;
            2'd1: r_sda_low <= w_ack_slot ? 1'b0 : ~r_shift[23];
            2'd2: r_scl_low <= 1'b0;
            2'd3: begin
              if (w_ack_slot) r_ack   <= r_ack | I2C_SDA;
              else            r_shift <= {r_shift[22:0], 1'b0};
            end
          endcase
        end
        if (r_phase == 2'd3) begin
          r_slot <= r_slot + 5'd1;
          if (r_slot != 5'd0) r_bit <= w_ack_slot ? 4'd0 : r_bit + 4'd1;
        end
      end
    end
  end

  assign END     = ~r_busy;
  assign ACK     = r_ack;
  assign I2C_SCL = ~r_scl_low;
  assign I2C_SDA = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: rtl/i2c_seq_config.sv
// Table-driven I2C register sequencer: walks WRITE/DELAY/END entries, retries NACKed writes.
//   state       | meaning
//   S_WAIT_IDLE | after reset, hold off until the i2c master reports END
//   S_IDLE      | sequence not running, waiting for start
//   S_FETCH     | table read cycle, decode entry
//   S_ISSUE     | raise START for the current WRITE
//   S_WAIT_BUSY | wait for the master to accept the frame
//   S_WAIT_END  | wait for frame completion, act on ACK
//   S_DELAY     | count down a DELAY entry
//   S_FINISH    | flag done, drop busy
module i2c_seq_config
  import i2c_seq_pkg::*;
#(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         I2C_HZ     = 20_000,
  parameter logic [7:0] SLAVE_ADDR = 8'h72,
  parameter int         AW         = 8,
  parameter int         MAX_RETRY  = 3,
  parameter int         DELAY_UNIT = 50_000,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          start,
  output logic [AW-1:0] tbl_addr,
  input  logic [17:0]   tbl_data,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    nack_cnt,
  output logic          I2C_SCL,
  inout  wire           I2C_SDA
);

  seq_state_t    r_state, w_state_nx;
  seq_entry_t    w_entry;
  logic [AW-1:0] r_tbl_addr;
  logic          r_busy, r_done, r_error, r_start, r_pending;
  logic [7:0]    r_nack_cnt;
  logic [3:0]    r_retry;
  logic [23:0]   r_delay;
  logic          w_i2c_end, w_i2c_ack;
  logic          w_go, w_auto, w_restart, w_begin, w_addr_last, w_retry_ok;
  seq_state_t    w_adv_state;

  assign w_entry     = seq_entry_t'(tbl_data);
  assign w_addr_last = &r_tbl_addr;
  assign w_adv_state = w_addr_last ? S_FINISH : S_FETCH;
  assign w_retry_ok  = (r_retry < 4'(MAX_RETRY));
  assign w_go        = start | r_pending;
  assign w_auto      = (r_state == S_WAIT_IDLE) && w_i2c_end && AUTO_START && !w_go;
  // A pending restart only takes effect at points where no frame is in flight.
  assign w_restart   = r_pending && ((r_state == S_FETCH) || (r_state == S_DELAY) ||
                                     ((r_state == S_WAIT_END) && w_i2c_end));
  assign w_begin     = w_auto || w_restart || ((r_state == S_IDLE) && w_go);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_WAIT_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_WAIT_IDLE: if (w_i2c_end) w_state_nx = w_auto ? S_FETCH : S_IDLE;
      S_IDLE:      if (w_go) w_state_nx = S_FETCH;
      S_FETCH: begin
        if (r_pending)                        w_state_nx = S_FETCH;
        else if (w_entry.op == OP_WRITE)      w_state_nx = S_ISSUE;
        else if (w_entry.op == OP_DELAY)      w_state_nx = (w_entry.data == 8'd0) ? w_adv_state : S_DELAY;
        else                                  w_state_nx = S_FINISH;
      end
      S_ISSUE:     w_state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!w_i2c_end) w_state_nx = S_WAIT_END;
      S_WAIT_END: begin
        if (w_i2c_end) begin
          if (r_pending)                    w_state_nx = S_FETCH;
          else if (w_i2c_ack && w_retry_ok) w_state_nx = S_ISSUE;
          else                              w_state_nx = w_adv_state;
        end
      end
      S_DELAY: begin
        if (r_pending)              w_state_nx = S_FETCH;
        else if (r_delay == 24'd0)  w_state_nx = w_adv_state;
      end
      S_FINISH:    w_state_nx = S_IDLE;
      default:     w_state_nx = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_tbl_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_nack_cnt <= 8'd0;
      r_start    <= 1'b0;
      r_pending  <= 1'b0;
      r_retry    <= 4'd0;
      r_delay    <= 24'd0;
    end else begin
      r_pending <= w_begin ? 1'b0 : (r_pending | start);
      if (w_begin) begin
        r_tbl_addr <= '0;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
        r_nack_cnt <= 8'd0;
        r_retry    <= 4'd0;
      end else begin
        case (r_state)
          S_FETCH: begin
            if (w_entry.op == OP_DELAY) begin
              if (w_entry.data == 8'd0) begin
                if (!w_addr_last) r_tbl_addr <= r_tbl_addr + 1'b1;
              end else begin
                r_delay <= 24'(w_entry.data) * 24'(DELAY_UNIT) - 24'd1;
              end
            end
          end
          S_ISSUE:     r_start <= 1'b1;
          S_WAIT_BUSY: if (!w_i2c_end) r_start <= 1'b0;
          S_WAIT_END: begin
            if (w_i2c_end) begin
              if (w_i2c_ack) begin
                if (r_nack_cnt != 8'hFF) r_nack_cnt <= r_nack_cnt + 8'd1;
                if (w_retry_ok) begin
                  r_retry <= r_retry + 4'd1;
                end else begin
                  r_error <= 1'b1;
                  r_retry <= 4'd0;
                  if (!w_addr_last) r_tbl_addr <= r_tbl_addr + 1'b1;
                end
              end else begin
                r_retry <= 4'd0;
                if (!w_addr_last) r_tbl_addr <= r_tbl_addr + 1'b1;
              end
            end
          end
          S_DELAY: begin
            if (r_delay == 24'd0) begin
              if (!w_addr_last) r_tbl_addr <= r_tbl_addr + 1'b1;
            end else begin
              r_delay <= r_delay - 24'd1;
            end
          end
          S_FINISH: begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  i2c #(CLK_HZ, I2C_HZ) u_i2c (
    .iCLK     (iCLK),
    .START    (r_start),
    .I2C_DATA ({SLAVE_ADDR, w_entry.regaddr, w_entry.data}),
    .END      (w_i2c_end),
    .ACK      (w_i2c_ack),
    .I2C_SCL  (I2C_SCL),
    .I2C_SDA  (I2C_SDA)
  );

  assign tbl_addr = r_tbl_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign nack_cnt = r_nack_cnt;

endmodule
